// File: rtl/piece_motion_ctrl.sv
// piece_motion_ctrl
// Owns the position of the single falling block in the play field. Applies
// gravity, left/right moves, soft drop and hard drop from decoded keyboard
// events, clamps the block to the field and exports its pixel bounding box.
//
// Ports:
//   clk            system clock
//   rst            asynchronous reset, active-low
//   enable         high = run; low = freeze gravity/hold counters, drop keys
//   key_valid      one-cycle pulse when last_change is updated
//   last_change    {extended, scancode} of the latest key event
//   key_down       per-key pressed state, indexed by last_change
//   ctrl_upMost    top y of piece box (inclusive)
//   ctrl_downMost  bottom y of piece box (exclusive)
//   ctrl_leftMost  left x of piece box
//   ctrl_rightMost right x of piece box
//   landed         one-cycle pulse on entry to LANDED
//   piece_state    0 FALL, 1 DROP, 2 LANDED, 3 SPAWN
module piece_motion_ctrl #(
  parameter int unsigned FIELD_LEFT = 220,
  parameter int unsigned FIELD_TOP  = 0,
  parameter int unsigned CELL       = 20,
  parameter int unsigned FIELD_COLS = 10,
  parameter int unsigned FIELD_ROWS = 20,
  parameter int unsigned PW         = 2,
  parameter int unsigned PH         = 2,
  parameter int unsigned SPAWN_COL  = 4,
  parameter int unsigned GRAV_DIV   = 25000000,
  parameter int unsigned LAND_HOLD  = 50000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         key_valid,
  input  logic [8:0]   last_change,
  input  logic [511:0] key_down,
  output logic [9:0]   ctrl_upMost,
  output logic [9:0]   ctrl_downMost,
  output logic [9:0]   ctrl_leftMost,
  output logic [9:0]   ctrl_rightMost,
  output logic         landed,
  output logic [1:0]   piece_state
);

  localparam int unsigned COLMAX = FIELD_COLS - PW;
  localparam int unsigned ROWMAX = FIELD_ROWS - PH;
  localparam int unsigned CW     = (COLMAX > 0) ? $clog2(COLMAX + 1) : 1;
  localparam int unsigned RW     = (ROWMAX > 0) ? $clog2(ROWMAX + 1) : 1;
  localparam int unsigned GW     = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;
  localparam int unsigned HW     = (LAND_HOLD > 1) ? $clog2(LAND_HOLD) : 1;

  localparam logic [8:0] KEY_LEFT  = 9'h16B;
  localparam logic [8:0] KEY_RIGHT = 9'h174;
  localparam logic [8:0] KEY_DOWN  = 9'h172;
  localparam logic [8:0] KEY_DROP  = 9'h029;

  typedef enum logic [1:0] {
    S_FALL   = 2'd0,
    S_DROP   = 2'd1,
    S_LANDED = 2'd2,
    S_SPAWN  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] col, col_nxt;
  logic [RW-1:0] row, row_nxt;
  logic [GW-1:0] gcnt, gcnt_nxt;
  logic [HW-1:0] hcnt, hcnt_nxt;
  logic          landed_nxt;

  // Key decode: only presses count, releases (bit = 0) are ignored
  logic press;
  logic press_left, press_right, press_down, press_drop;
  logic gtick, htick;

  assign press       = key_valid & key_down[last_change];
  assign press_left  = press & (last_change == KEY_LEFT);
  assign press_right = press & (last_change == KEY_RIGHT);
  assign press_down  = press & (last_change == KEY_DOWN);
  assign press_drop  = press & (last_change == KEY_DROP);
  assign gtick       = (gcnt == GW'(GRAV_DIV - 1));
  assign htick       = (hcnt == HW'(LAND_HOLD - 1));

  // State and position registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_FALL;
      col    <= CW'(SPAWN_COL);
      row    <= '0;
      gcnt   <= '0;
      hcnt   <= '0;
      landed <= 1'b0;
    end else begin
      state  <= state_nxt;
      col    <= col_nxt;
      row    <= row_nxt;
      gcnt   <= gcnt_nxt;
      hcnt   <= hcnt_nxt;
      landed <= landed_nxt;
    end
  end

  // Next-state, motion and counter logic
  always_comb begin
    state_nxt  = state;
    col_nxt    = col;
    row_nxt    = row;
    gcnt_nxt   = gcnt;
    hcnt_nxt   = hcnt;
    landed_nxt = 1'b0;
    case (state)
      S_FALL: begin
        if (enable) begin
          gcnt_nxt = gtick ? '0 : gcnt + GW'(1);
          if (press_drop) begin
            // Hard drop overrides a coincident gravity tick
            state_nxt = S_DROP;
            gcnt_nxt  = '0;
          end else begin
            if (press_left && (col != '0))
              col_nxt = col - CW'(1);
            if (press_right && (col < CW'(COLMAX)))
              col_nxt = col + CW'(1);
            // Soft drop restarts the gravity period
            if (press_down)
              gcnt_nxt = '0;
            // Tick and soft drop in the same cycle still move one row
            if (gtick || press_down) begin
              if (row < RW'(ROWMAX)) begin
                row_nxt = row + RW'(1);
              end else begin
                state_nxt  = S_LANDED;
                landed_nxt = 1'b1;
              end
            end
          end
        end
      end
      S_DROP: begin
        if (row < RW'(ROWMAX)) begin
          row_nxt = row + RW'(1);
        end else begin
          state_nxt  = S_LANDED;
          landed_nxt = 1'b1;
        end
      end
      S_LANDED: begin
        if (enable) begin
          if (htick) begin
            hcnt_nxt  = '0;
            state_nxt = S_SPAWN;
          end else begin
            hcnt_nxt = hcnt + HW'(1);
          end
        end
      end
      S_SPAWN: begin
        row_nxt   = '0;
        col_nxt   = CW'(SPAWN_COL);
        gcnt_nxt  = '0;
        state_nxt = S_FALL;
      end
    endcase
  end

  // Pixel bounding box derived from the cell position
  assign ctrl_leftMost  = 10'(FIELD_LEFT) + 10'(col) * 10'(CELL);
  assign ctrl_rightMost = ctrl_leftMost + 10'(PW * CELL);
  assign ctrl_upMost    = 10'(FIELD_TOP) + 10'(row) * 10'(CELL);
  assign ctrl_downMost  = ctrl_upMost + 10'(PH * CELL);
  assign piece_state    = state;

endmodule

// File: doc/piece_motion_ctrl.md
Name: piece_motion_ctrl

Overview:
- Owns the position of the single falling block in the Tetris play field.
- Consumes decoded keyboard events (key_valid / last_change / key_down) and applies gravity, left/right moves, soft drop and hard drop, with clamping to the field.
- Produces the pixel bounding box (ctrl_upMost / ctrl_downMost / ctrl_leftMost / ctrl_rightMost) consumed downstream by the VGA compositing stage, which selects the sprite pixel over the background inside that box.

Parameters:
FIELD_LEFT, 220, x pixel of the field's left edge
FIELD_TOP, 0, y pixel of the field's top edge
CELL, 20, cell size in pixels
FIELD_COLS, 10, field width in cells
FIELD_ROWS, 20, field height in cells
PW, 2, piece width in cells
PH, 2, piece height in cells
SPAWN_COL, 4, spawn column
GRAV_DIV, 25000000, clk cycles per gravity step
LAND_HOLD, 50000000, clk cycles spent in LANDED before respawn

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  asynchronous reset, active-low
enable  in  1  high = run; low = freeze gravity counter and ignore keys
key_valid  in  1  one-cycle pulse when last_change is updated
last_change  in  9  {extended, scancode} of the latest key event
key_down  in  512  per-key pressed state
ctrl_upMost  out  10  top y of piece box (inclusive)
ctrl_downMost  out  10  bottom y of piece box (exclusive)
ctrl_leftMost  out  10  left x of piece box
ctrl_rightMost  out  10  right x of piece box
landed  out  1  one-cycle pulse on entry to LANDED
piece_state  out  2  0 FALL, 1 DROP, 2 LANDED, 3 SPAWN

Behaviour:
- Internal registers:
  - col: 0..FIELD_COLS-PW (COLMAX = 8)
  - row: 0..FIELD_ROWS-PH (ROWMAX = 18)
  - gravity counter gcnt, hold counter hcnt, 2-bit state.
- Geometry outputs are combinational from col/row, so a change is visible the cycle after the event:
  - leftMost = FIELD_LEFT + col*CELL
  - rightMost = leftMost + PW*CELL
  - upMost = FIELD_TOP + row*CELL
  - downMost = upMost + PH*CELL
  - All arithmetic is 10-bit. Parameters must satisfy FIELD_LEFT + COLS*CELL ≤ 639 and FIELD_TOP + ROWS*CELL ≤ 479.
- Reset (rst = 0, asynchronous): state = FALL, col = SPAWN_COL, row = 0, gcnt = hcnt = 0, landed = 0. With defaults this gives left 300, right 340, up 0, down 40.
- Key press event: key_valid = 1 && key_down[last_change] = 1. Release events (bit = 0) are ignored.
  - LEFT = 9'h16B, RIGHT = 9'h174, DOWN = 9'h172, DROP = 9'h029 (space). Any other code is ignored.
- FALL (only when enable = 1):
  - gcnt increments each cycle. At gcnt == GRAV_DIV-1 it is a gravity tick: gcnt <= 0; row+1 if row < ROWMAX, else go to LANDED.
  - LEFT: col-1 if col > 0, otherwise no change. RIGHT: col+1 if col < COLMAX, otherwise no change.
  - DOWN: row+1 if row < ROWMAX and gcnt <= 0. If row == ROWMAX, go to LANDED.
  - DROP: go to DROP state; gcnt <= 0.
  - Gravity tick together with LEFT/RIGHT in the same cycle: both apply.
  - Gravity tick together with DOWN: row advances exactly once.
  - Gravity tick together with DROP: DROP wins; no row change that cycle.
- DROP: row+1 every cycle while row < ROWMAX. At ROWMAX, go to LANDED. Keys are ignored; enable is not checked.
- LANDED:
  - landed = 1 for the entry cycle only.
  - hcnt counts 0..LAND_HOLD-1. At the terminal count: hcnt <= 0, go to SPAWN.
  - Keys are ignored. hcnt freezes while enable = 0.
- SPAWN: single cycle. row <= 0, col <= SPAWN_COL, gcnt <= 0, then go to FALL.
- enable = 0 in FALL: position and gcnt hold; key events are dropped, not queued.
- Reset asserted mid-DROP or mid-LANDED: immediately returns to the reset values; no landed pulse.
- key_valid held high for several cycles with the same press: each high cycle counts as one event. The upstream decoder guarantees single-cycle pulses.

Test Plan (GRAV_DIV = 8, LAND_HOLD = 4):
1. Reset, then release rst with enable = 1 and no keys -> row increments every 8 cycles; upMost goes 0, 20, 40 …; after 18 steps, landed pulses once and piece_state = 2 for 4 cycles, then 3 for one cycle, then FALL with up = 0, left = 300.
2. Eight LEFT presses, then one more -> leftMost goes 300 → 220 after 4 presses and stays 220. Nine RIGHT presses from col 0 -> rightMost stops at 420 (col 8).
3. DROP at row 0 -> piece_state = 1; upMost increments by 20 per cycle for 18 cycles to 360 (downMost 400); landed pulses on the next cycle.
4. DOWN asserted exactly on the gravity-tick cycle at row 3 -> row becomes 4, not 5; the next gravity step comes 8 cycles later.
5. enable = 0 for 20 cycles in FALL with LEFT presses -> col, row and gcnt are unchanged. Release of LEFT (key_down bit = 0, key_valid = 1) -> no move.
6. Assert rst during DROP at row 10 -> outputs return immediately (asynchronously) to 0/40/300/340, piece_state = 0, landed never pulses.
